// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Ceiling log2 for sizing counters; returns at least 1 so a counter never collapses to zero bits.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Binary input / BCD result bundle between a value source and the converter.
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] bcd;
  logic                valid;
  logic                overflow;

  modport master (
    output bin,
    input  bcd,
    input  valid,
    input  overflow
  );

  modport slave (
    input  bin,
    output bcd,
    output valid,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: adds 3 to a nibble of 5 or more, purely combinational.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Wraps within 4 bits on purpose; digits never carry into their neighbour.
  assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_conv.sv
// Free-running shift/add-3 converter: LOAD samples bin, WIDTH SHIFT cycles, COMMIT updates outputs.
module bin2bcd_conv
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic     clk,
  input logic     reset,
  bin2bcd_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  if (WIDTH < 1 || WIDTH > 16 || DIGITS < 1 || DIGITS > 5) begin : g_param_check
    $error("bin2bcd_conv: WIDTH must be 1..16 and DIGITS 1..5");
  end

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_adj;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_q;
  logic               valid_q;
  logic               overflow_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_adj u_adj (
      .din  (work[4*d +: 4]),
      .dout (work_adj[4*d +: 4])
    );
  end

  // NOTE: state registers use non-blocking assignments so every register in this block
  // samples the pre-edge values; blocking here would chain shreg into work within one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      shreg      <= '0;
      work       <= '0;
      ovf_acc    <= 1'b0;
      cnt        <= '0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= bus.bin;
          work    <= '0;
          ovf_acc <= 1'b0;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // A 1 leaving the top digit means the value needs another digit: record it as overflow.
          work    <= {work_adj[BCD_W-2:0], shreg[WIDTH-1]};
          shreg   <= shreg << 1;
          ovf_acc <= ovf_acc | work_adj[BCD_W-1];
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_q      <= work;
          overflow_q <= ovf_acc;
          valid_q    <= 1'b1;
          state      <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed checks of bin2bcd_conv in three configurations: 8b/3 digits, 6b/2 digits, 8b/2 digits.
module tb_bin2bcd_conv;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_if #(.WIDTH(8), .DIGITS(3)) if_a ();
  bin2bcd_if #(.WIDTH(6), .DIGITS(2)) if_b ();
  bin2bcd_if #(.WIDTH(8), .DIGITS(2)) if_c ();

  bin2bcd_conv #(.WIDTH(8), .DIGITS(3)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  bin2bcd_conv #(.WIDTH(6), .DIGITS(2)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  bin2bcd_conv #(.WIDTH(8), .DIGITS(2)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // n rising edges, then return on the following falling edge (safe sample / drive point).
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Returns on the falling edge right after release; the next rising edge is the LOAD edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [11:0] ref_bcd3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic nibbles_ok(input logic [11:0] b);
    for (int d = 0; d < 3; d++) begin
      if (b[4*d +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    logic [11:0] prev;
    logic        stable;
    logic        found;

    reset     = 1'b1;
    if_a.bin  = '0;
    if_b.bin  = '0;
    if_c.bin  = '0;

    // Reset state of every instance while reset is held low.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_a_bcd",   32'(if_a.bcd),      32'h0);
    check("rst_a_valid", 32'(if_a.valid),    32'h0);
    check("rst_a_ovf",   32'(if_a.overflow), 32'h0);
    check("rst_b_bcd",   32'(if_b.bcd),      32'h0);
    check("rst_c_valid", 32'(if_c.valid),    32'h0);

    // Test 1: 255 held, result lands on the 10th edge after release, not before.
    if_a.bin = 8'd255;
    do_reset();
    cycles(9);
    check("t1_valid_early", 32'(if_a.valid), 32'h0);
    check("t1_bcd_early",   32'(if_a.bcd),   32'h0);
    cycles(1);
    check("t1_bcd",   32'(if_a.bcd),      32'h255);
    check("t1_valid", 32'(if_a.valid),    32'h1);
    check("t1_ovf",   32'(if_a.overflow), 32'h0);

    // Test 2: 6-bit sweep, one commit every 8 cycles.
    if_b.bin = '0;
    do_reset();
    for (int v = 0; v < 64; v++) begin
      if_b.bin = 6'(v);
      cycles(8);
      check($sformatf("t2_bcd_%0d", v), 32'(if_b.bcd), 32'({4'(v / 10), 4'(v % 10)}));
      check($sformatf("t2_ovf_%0d", v), 32'(if_b.overflow), 32'h0);
    end

    // Test 3: two-digit result of an 8-bit value, overflow then clear.
    if_c.bin = 8'd123;
    do_reset();
    cycles(10);
    check("t3_123_bcd",   32'(if_c.bcd),      32'h23);
    check("t3_123_ovf",   32'(if_c.overflow), 32'h1);
    check("t3_123_valid", 32'(if_c.valid),    32'h1);
    if_c.bin = 8'd99;
    cycles(10);
    check("t3_99_bcd", 32'(if_c.bcd),      32'h99);
    check("t3_99_ovf", 32'(if_c.overflow), 32'h0);

    // Test 4: input change mid-SHIFT only affects the following conversion.
    if_a.bin = 8'd45;
    do_reset();
    cycles(3);
    if_a.bin = 8'd200;
    cycles(6);
    check("t4_hold", 32'(if_a.bcd), 32'h0);
    cycles(1);
    check("t4_first", 32'(if_a.bcd), 32'h045);
    cycles(10);
    check("t4_second", 32'(if_a.bcd), 32'h200);

    // Test 5: asynchronous reset during SHIFT, then recovery.
    if_a.bin = 8'd255;
    do_reset();
    cycles(10);
    check("t5_pre", 32'(if_a.bcd), 32'h255);
    cycles(3);
    reset = 1'b0;
    #1;
    check("t5_bcd",   32'(if_a.bcd),      32'h0);
    check("t5_valid", 32'(if_a.valid),    32'h0);
    check("t5_ovf",   32'(if_a.overflow), 32'h0);
    if_a.bin = 8'd7;
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      if (if_a.valid === 1'b1 && if_a.bcd === 12'h007) found = 1'b1;
    end
    check("t5_recover", 32'(found), 32'h1);

    // Test 6: exhaustive 8-bit against a division model, with digit-range and stability checks.
    if_a.bin = '0;
    do_reset();
    prev = 12'h000;
    for (int v = 0; v < 256; v++) begin
      if_a.bin = 8'(v);
      stable = 1'b1;
      for (int e = 0; e < 9; e++) begin
        cycles(1);
        if (if_a.bcd !== prev) stable = 1'b0;
      end
      cycles(1);
      check($sformatf("t6_bcd_%0d", v),    32'(if_a.bcd),             32'(ref_bcd3(v)));
      check($sformatf("t6_digits_%0d", v), 32'(nibbles_ok(if_a.bcd)), 32'h1);
      check($sformatf("t6_stable_%0d", v), 32'(stable),               32'h1);
      check($sformatf("t6_ovf_%0d", v),    32'(if_a.overflow),        32'h0);
      prev = ref_bcd3(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
